bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
- Two-digit (00–99) BCD up/down counter with prescaler, synchronous load and wrap carry.
- Sits directly upstream of the BCD-to-7-segment decoder.
- `ones` and `tens` each drive one decoder instance's 4-bit input. Every value the block presents is a legal BCD digit 0–9.

Parameters:
- PRESCALE, default 4: number of enabled clock cycles per count step. Legal range ≥1; 1 means step on every enabled cycle.
- PW, default $clog2(PRESCALE) (minimum 1): prescaler counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  count enable; prescaler advances only while high
- up  input  1  direction: 1 = increment, 0 = decrement; sampled on the step cycle
- load  input  1  synchronous load strobe
- load_val  input  8  [7:4] tens digit, [3:0] ones digit
- ones  output  4  current ones digit, 0–9
- tens  output  4  current tens digit, 0–9
- carry  output  1  one-cycle pulse on wrap: 99→00 going up, or 00→99 going down
- load_err  output  1  one-cycle pulse when a loaded digit was >9
- step  output  1  one-cycle pulse on every cycle in which the count changed due to counting

Behaviour:
- All state is registered on the rising edge of clk.
- Priority order: reset > load > count.

Reset:
- Values: ones=0, tens=0, carry=0, load_err=0, step=0, prescaler=0.
- Reset asserted mid-step overrides everything; the next cycle shows 00 with no pulses.

Load:
- Applied when load=1, regardless of en.
- Each digit field >9 is replaced by 0. load_err=1 for that cycle if either field was >9.
- Prescaler clears to 0. carry=0, step=0 that cycle.
- Loaded value is visible on outputs the cycle after load is sampled.

Prescaler:
- When en=1 and load=0:
  - If prescaler == PRESCALE-1: prescaler←0 and a count step occurs.
  - Otherwise: prescaler←prescaler+1.
- When en=0: prescaler holds and the count holds.
- First step occurs PRESCALE enabled cycles after reset or load.

Count step, up=1:
- ones<9: ones+1.
- ones==9: ones←0 and tens increments.
- tens==9 with ones==9: tens←0, ones←0, carry=1.

Count step, up=0:
- ones>0: ones−1.
- ones==0: ones←9 and tens decrements.
- tens==0 with ones==0: both←9, carry=1.

Pulse rules:
- step=1 on every count-step cycle, coincident with the updated digits.
- carry pulses coincide with the updated (wrapped) digits. carry is 0 in every non-step cycle.
- load_err is 0 in every non-load cycle.

Other boundaries:
- A direction change between steps takes effect at the next step. The prescaler is not reset by a direction change.
- load and a terminal prescaler count in the same cycle: load wins, no step, no carry.
- en falling mid-interval: prescaler value is retained and counting resumes from it.
- The ones/tens registers never hold 10–15 in any cycle.

Decomposition:
- Shared package `bcd_pkg`:
  - BCD_W=4, BCD_MAX=4'd9, BCD_ZERO=4'd0
  - Function `bcd_sat_valid(digit)` returning the digit, or 0 when >9
- Sub-module `bcd_digit`: one-digit up/down cell.
  - Inputs: clk, reset, load, load_digit, inc, dec.
  - Outputs: digit, wrap.
  - Wrap is combinational terminal-state and ripples to the next cell.
- Top level: prescaler, two `bcd_digit` instances (tens cell enabled by the ones cell's wrap), and registered pulses.

Test Plan:
1. Reset held 2 cycles, PRESCALE=4, en=1, up=1 → ones=0, tens=0 with no pulses. First step 4 cycles after reset release gives 01; step pulses every 4th cycle.
2. load_val=8'h98, up=1, en=1 → 98, then 99, then 00 with carry=1 in exactly that cycle. Next step gives 01 with carry=0.
3. load_val=8'h00, up=0 → next step gives 99 with carry=1, then 98. Load 8'h10, one step down → 09 with no carry.
4. load_val=8'hA7 → outputs 07, load_err=1 for one cycle. load_val=8'h3F → outputs 30, load_err=1.
5. en=1 for 2 cycles, then en=0 for 10 cycles, then en=1 → step occurs after exactly 2 more enabled cycles. Count is frozen while en=0.
6. load asserted in the same cycle the prescaler reaches 3 with value 99, up=1 → no carry, outputs equal load_val. reset asserted mid-count → 00 the next cycle.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and a helper for sanitising digits on load.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

    // Illegal BCD codes (10-15) collapse to zero so a digit register never holds them.
    function automatic logic [BCD_W-1:0] bcd_sat_valid(input logic [BCD_W-1:0] digit);
        return (digit > BCD_MAX) ? BCD_ZERO : digit;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit cell counting 0-9 in either direction; wrap flags the terminal
// state combinationally so the next cell up can ripple from it.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    input  logic             inc,
    input  logic             dec,
    output logic [BCD_W-1:0] digit,
    output logic             wrap
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    assign wrap  = (inc && (digit_q == BCD_MAX)) || (dec && (digit_q == BCD_ZERO));
    assign digit = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_sat_valid(load_digit);
        end else if (inc) begin
            digit_d = (digit_q == BCD_MAX) ? BCD_ZERO : digit_q + 4'd1;
        end else if (dec) begin
            digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= BCD_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Two-digit BCD up/down counter with enable prescaler, synchronous load and
// wrap carry; feeds a pair of BCD-to-7-segment decoders.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [7:0]       load_val,
    output logic [BCD_W-1:0] ones,
    output logic [BCD_W-1:0] tens,
    output logic             carry,
    output logic             load_err,
    output logic             step
);

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          step_q;
    logic          carry_q;
    logic          err_q;
    logic          err_d;

    logic stepNow;
    logic onesInc;
    logic onesDec;
    logic onesWrap;
    logic tensWrap;

    // Load outranks the terminal prescaler count, so a load cycle never steps.
    assign stepNow = en && !load && (pre_q == PRE_LAST);
    assign onesInc = stepNow && up;
    assign onesDec = stepNow && !up;

    always_comb begin
        pre_d = pre_q;
        if (load) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = stepNow ? '0 : pre_q + 1'b1;
        end
    end

    assign err_d = load && ((load_val[7:4] > BCD_MAX) || (load_val[3:0] > BCD_MAX));

    bcd_digit u_ones (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_digit (load_val[3:0]),
        .inc        (onesInc),
        .dec        (onesDec),
        .digit      (ones),
        .wrap       (onesWrap)
    );

    // Tens only moves when the ones cell rolls over; its own wrap is the full carry.
    bcd_digit u_tens (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_digit (load_val[7:4]),
        .inc        (onesInc && onesWrap),
        .dec        (onesDec && onesWrap),
        .digit      (tens),
        .wrap       (tensWrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            step_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            step_q  <= stepNow;
            carry_q <= tensWrap;
            err_q   <= err_d;
        end
    end

    assign step     = step_q;
    assign carry    = carry_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomised and directed checks of bcd_updown_counter against an integer-valued model.
module tb_bcd_updown_counter;

    localparam int PRESCALE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       carry;
    logic       load_err;
    logic       step;

    int checks = 0;
    int failures = 0;

    // Model state: the count as a plain integer 0..99 plus an enabled-cycle counter.
    int   mVal = 0;
    int   mPre = 0;
    logic mStep = 1'b0;
    logic mCarry = 1'b0;
    logic mErr = 1'b0;

    bcd_updown_counter #(.PRESCALE(PRESCALE)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .ones     (ones),
        .tens     (tens),
        .carry    (carry),
        .load_err (load_err),
        .step     (step)
    );

    always #5 clk = ~clk;

    task automatic modelUpdate();
        int t;
        int o;
        mStep  = 1'b0;
        mCarry = 1'b0;
        mErr   = 1'b0;
        if (reset) begin
            mVal = 0;
            mPre = 0;
        end else if (load) begin
            t = int'(load_val[7:4]);
            o = int'(load_val[3:0]);
            mErr = (t > 9) || (o > 9);
            if (t > 9) t = 0;
            if (o > 9) o = 0;
            mVal = t * 10 + o;
            mPre = 0;
        end else if (en) begin
            if (mPre == PRESCALE - 1) begin
                mPre  = 0;
                mStep = 1'b1;
                if (up) begin
                    mCarry = (mVal == 99);
                    mVal   = (mVal + 1) % 100;
                end else begin
                    mCarry = (mVal == 0);
                    mVal   = (mVal + 99) % 100;
                end
            end else begin
                mPre = mPre + 1;
            end
        end
    endtask

    function automatic logic [10:0] modelVec();
        return {4'(mVal / 10), 4'(mVal % 10), mStep, mCarry, mErr};
    endfunction

    task automatic tick();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    // Advance until the DUT raises step, giving up after a bounded number of cycles.
    task automatic runToStep(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!step && cycles < 4 * PRESCALE);
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({tens, ones, step, carry, load_err} !== 11'd0) begin
                failures++;
                $display("[TB] FAIL reset_hold: got %h%h s%b c%b e%b, want 00 with no pulses", tens, ones, step, carry, load_err);
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= 2 * PRESCALE; i++) begin
            tick();
            checks++;
            if (i == PRESCALE || i == 2 * PRESCALE) begin
                if ({tens, ones, step} !== {4'd0, 4'(i / PRESCALE), 1'b1}) begin
                    failures++;
                    $display("[TB] FAIL first_steps cycle %0d: got %h%h step=%b, want 0%0d step=1", i, tens, ones, step, i / PRESCALE);
                end
            end else if ({tens, ones, step} !== {4'd0, 4'(i / PRESCALE), 1'b0}) begin
                failures++;
                $display("[TB] FAIL between_steps cycle %0d: got %h%h step=%b, want 0%0d step=0", i, tens, ones, step, i / PRESCALE);
            end
        end
    endtask

    task automatic test_up_wrap();
        logic [8:0] expSeq [3] = '{{4'd9, 4'd9, 1'b0}, {4'd0, 4'd0, 1'b1}, {4'd0, 4'd1, 1'b0}};
        int n;
        load = 1'b1; load_val = 8'h98; up = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if ({tens, ones} !== 8'h98) begin
            failures++;
            $display("[TB] FAIL load_98: got %h%h, want 98", tens, ones);
        end
        for (int k = 0; k < 3; k++) begin
            runToStep(n);
            checks++;
            if (n != PRESCALE || {tens, ones, carry} !== expSeq[k]) begin
                failures++;
                $display("[TB] FAIL up_wrap step %0d: got %h%h carry=%b after %0d cycles, want %h carry=%b after %0d", k, tens, ones, carry, n, expSeq[k][8:1], expSeq[k][0], PRESCALE);
            end
        end
    endtask

    task automatic test_down_wrap();
        int n;
        load = 1'b1; load_val = 8'h00; up = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        runToStep(n);
        checks++;
        if ({tens, ones, carry} !== {8'h99, 1'b1}) begin
            failures++;
            $display("[TB] FAIL down_wrap: got %h%h carry=%b, want 99 carry=1", tens, ones, carry);
        end
        runToStep(n);
        checks++;
        if ({tens, ones, carry} !== {8'h98, 1'b0}) begin
            failures++;
            $display("[TB] FAIL down_98: got %h%h carry=%b, want 98 carry=0", tens, ones, carry);
        end
        load = 1'b1; load_val = 8'h10;
        tick();
        load = 1'b0;
        runToStep(n);
        checks++;
        if ({tens, ones, carry} !== {8'h09, 1'b0}) begin
            failures++;
            $display("[TB] FAIL down_borrow: got %h%h carry=%b, want 09 carry=0", tens, ones, carry);
        end
    endtask

    task automatic test_load_err();
        logic [7:0] vals [2] = '{8'hA7, 8'h3F};
        logic [7:0] want [2] = '{8'h07, 8'h30};
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            load = 1'b1; load_val = vals[k];
            tick();
            load = 1'b0;
            checks++;
            if ({tens, ones, load_err} !== {want[k], 1'b1}) begin
                failures++;
                $display("[TB] FAIL load_err %h: got %h%h err=%b, want %h err=1", vals[k], tens, ones, load_err, want[k]);
            end
            tick();
            checks++;
            if (load_err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL load_err_clear %h: got err=%b, want 0", vals[k], load_err);
            end
        end
    endtask

    task automatic test_enable_gap();
        load = 1'b1; load_val = 8'h25; up = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({tens, ones, step} !== {8'h25, 1'b0}) begin
                failures++;
                $display("[TB] FAIL frozen cycle %0d: got %h%h step=%b, want 25 step=0", i, tens, ones, step);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if ({tens, ones, step} !== {8'h25, 1'b0}) begin
            failures++;
            $display("[TB] FAIL resume_early: got %h%h step=%b, want 25 step=0", tens, ones, step);
        end
        tick();
        checks++;
        if ({tens, ones, step} !== {8'h26, 1'b1}) begin
            failures++;
            $display("[TB] FAIL resume_step: got %h%h step=%b, want 26 step=1", tens, ones, step);
        end
    endtask

    task automatic test_load_priority();
        logic [3:0] t;
        logic [3:0] o;
        t = 4'($urandom_range(0, 9));
        o = 4'($urandom_range(0, 9));
        load = 1'b1; load_val = 8'h99; up = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < PRESCALE - 1; i++) tick();
        load = 1'b1; load_val = {t, o};
        tick();
        load = 1'b0;
        checks++;
        if ({tens, ones, step, carry, load_err} !== {t, o, 3'b000}) begin
            failures++;
            $display("[TB] FAIL load_vs_step: got %h%h s%b c%b e%b, want %h%h no pulses", tens, ones, step, carry, load_err, t, o);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({tens, ones, step, carry, load_err} !== 11'd0) begin
            failures++;
            $display("[TB] FAIL reset_midcount: got %h%h s%b c%b e%b, want 00 no pulses", tens, ones, step, carry, load_err);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 99) < 2);
            load     = ($urandom_range(0, 99) < 5);
            en       = ($urandom_range(0, 99) < 75);
            up       = ($urandom_range(0, 99) < 60);
            load_val = 8'($urandom);
            tick();
            checks++;
            if ({tens, ones, step, carry, load_err} !== modelVec() || ones > 4'd9 || tens > 4'd9) begin
                failures++;
                $display("[TB] FAIL random cycle %0d: got %h%h s%b c%b e%b, want %0d s%b c%b e%b", i, tens, ones, step, carry, load_err, mVal, mStep, mCarry, mErr);
            end
        end
        reset = 1'b0; load = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_err();
        test_enable_gap();
        test_load_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
